// File: rtl/m_divider_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; start/busy/done handshake with kill abort.
module m_divider_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic [1:0]      op_sel;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            is_sgn;
  logic            a_neg;
  logic            b_neg;
  logic            div0;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] spec_rd;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] q_next;
  logic [XLEN-1:0] r_next;
  logic [XLEN-1:0] fin_rd;

  assign accept  = (state == IDLE) && start && !kill;
  assign is_sgn  = !sel[0];
  assign a_neg   = is_sgn && rs1[XLEN-1];
  assign b_neg   = is_sgn && rs2[XLEN-1];
  assign mag_a   = a_neg ? -rs1 : rs1;
  assign mag_b   = b_neg ? -rs2 : rs2;
  assign div0    = (rs2 == '0);
  assign ovf     = is_sgn && (rs1 == MIN) && (rs2 == '1);
  assign special = div0 || ovf;

  always_comb begin
    spec_rd = '0;
    if (div0)
      spec_rd = sel[1] ? rs1 : '1;
    else if (ovf)
      spec_rd = sel[1] ? '0 : MIN;
  end

  // Shift in the next dividend bit and trial-subtract with a borrow bit.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_comb begin
    if (!diff[XLEN]) begin
      r_next = diff[XLEN-1:0];
      q_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      r_next = shifted[XLEN-1:0];
      q_next = {quo[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    if (op_sel[1])
      fin_rd = neg_r ? -r_next : r_next;
    else
      fin_rd = neg_q ? -q_next : q_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = special ? DONE : CALC;
      end
      CALC: begin
        if (kill)
          state_n = IDLE;
        else if (cnt == LAST)
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sel <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      rd     <= '0;
    end else if (accept) begin
      op_sel <= sel;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      quo    <= mag_a;
      rem    <= '0;
      dvs    <= mag_b;
      cnt    <= '0;
      if (special)
        rd <= spec_rd;
    end else if (state == CALC && !kill) begin
      quo <= q_next;
      rem <= r_next;
      cnt <= cnt + 1'b1;
      if (cnt == LAST)
        rd <= fin_rd;
    end
  end

endmodule

// File: tb/tb_m_divider_seq.sv
// Self-checking bench for m_divider_seq: directed cases plus random
// operands checked against a plain-arithmetic RV32M reference.
module tb_m_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  sel;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rd;

  m_divider_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .kill  (kill),
    .sel   (sel),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .done  (done),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 0)
      return s[1] ? a : 32'hFFFF_FFFF;
    if (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return s[1] ? 32'h0 : 32'h8000_0000;
    case (s)
      2'd0:    return 32'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] s,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) ||
           (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic run_op(input string tag,
                        input logic [1:0] s,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] exp;
    int n;
    exp = model(s, a, b);
    sel = s;
    rs1 = a;
    rs2 = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    sel = 2'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), is_special(s, a, b) ? 32'd1 : 32'd33);
    check({tag, "_rd"}, rd, exp);
    last_rd = exp;
    tick();
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0] s;
    rst = 1'b1;
    start = 1'b0;
    kill = 1'b0;
    sel = 2'd0;
    rs1 = '0;
    rs2 = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd", rd, 32'd0);
    rst = 1'b0;
    tick();

    run_op("div_100_7", 2'd0, 32'd100, 32'd7);
    run_op("rem_100_7", 2'd2, 32'd100, 32'd7);
    run_op("div_m7_2", 2'd0, -32'sd7, 32'd2);
    run_op("rem_m7_2", 2'd2, -32'sd7, 32'd2);
    run_op("rem_7_m2", 2'd2, 32'd7, -32'sd2);
    run_op("divu_max_2", 2'd1, 32'hFFFF_FFFF, 32'd2);
    run_op("remu_max_2", 2'd3, 32'hFFFF_FFFF, 32'd2);
    run_op("div_z", 2'd0, 32'h1234_5678, 32'd0);
    run_op("divu_z", 2'd1, 32'h1234_5678, 32'd0);
    run_op("rem_z", 2'd2, 32'h1234_5678, 32'd0);
    run_op("remu_z", 2'd3, 32'h1234_5678, 32'd0);
    run_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Kill at iteration 10: no done, rd keeps the previous result.
    sel = 2'd1;
    rs1 = 32'd999;
    rs2 = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    check("kill_rd", rd, last_rd);
    repeat (3) tick();
    check("kill_nodone", {30'd0, busy, done}, 32'd0);
    run_op("after_kill", 2'd0, -32'sd1000, 32'd7);

    // Kill in IDLE wins over start.
    kill = 1'b1;
    start = 1'b1;
    tick();
    kill = 1'b0;
    start = 1'b0;
    check("kill_idle", 32'(busy), 32'd0);

    // A second start mid-calculation is ignored.
    sel = 2'd0;
    rs1 = 32'd5000;
    rs2 = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    sel = 2'd3;
    rs1 = 32'd77;
    rs2 = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) tick();
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_rd", rd, 32'd555);
    tick();

    for (int i = 0; i < 24; i++) begin
      s = 2'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) == 0)
        b = $urandom_range(0, 9);
      else
        b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1)
        b = -b;
      run_op("rand", s, a, b);
    end

    // Async reset mid-calculation clears outputs without a clock edge.
    sel = 2'd1;
    rs1 = 32'hDEAD_BEEF;
    rs2 = 32'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_rd", rd, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op("after_rst", 2'd2, 32'd123457, 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_divider_seq.md
Name: m_divider_seq

Overview:
- Iterative radix-2 restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Complements the single-cycle combinational multiplier in the M-extension execute unit, covering the inverse operation.
- Sits beside that multiplier in the EX stage of each core.
- Uses a start/busy/done handshake so the pipeline can stall while the divide is in flight, and a kill input so a flush can abort it.

Parameters:
- XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
- clk    input   1     rising-edge clock
- rst    input   1     asynchronous, active-high reset
- start  input   1     one-cycle request; sampled only in IDLE
- kill   input   1     pipeline flush; aborts any operation in flight
- sel    input   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0])
- rs1    input   XLEN  dividend
- rs2    input   XLEN  divisor
- busy   output  1     high while an operation is in flight (CALC or DONE)
- done   output  1     one-cycle pulse; rd is valid in this cycle
- rd     output  XLEN  result; holds its value until the next accepted start

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, done=0, rd=0.
  - Internal quotient, remainder, divisor and count registers cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - Only state that accepts start. start is accepted when start=1 and kill=0, on clock edge N.
  - At acceptance, latch sel, the sign flags and the operand magnitudes.
  - Signed ops (DIV, REM) use two's-complement magnitudes. Unsigned ops use raw values.
  - Special cases go IDLE->DONE with the result fixed at acceptance; done pulses in cycle N+1.
    - Divide by zero (rs2==0): DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> rs1.
    - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
  - Otherwise IDLE->CALC with count=0.
- CALC:
  - One quotient bit per cycle, restoring algorithm: shift {rem, quo} left by 1; trial-subtract the divisor from rem. If non-negative, keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - Remainder datapath is XLEN+1 bits wide to hold the trial difference.
  - After XLEN iterations (count==XLEN-1 on the final edge), go to DONE.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - rd is registered on entry to DONE:
    - Quotient is negated when signed and sign(rs1)!=sign(rs2).
    - Remainder is negated when signed and rs1 is negative, so its sign follows the dividend.
- Latency:
  - Normal path: start accepted at edge N, done high in cycle N+XLEN+1 (cycle 33 for XLEN=32).
  - Special cases: done high in cycle N+1.
- busy is 1 in CALC and DONE and 0 in IDLE. The pipeline stalls on start|busy.
- start while busy is ignored; it neither restarts nor queues.
- kill:
  - In CALC or DONE: next edge -> IDLE, busy=0, done=0, and rd is not updated.
  - In IDLE: kill has priority over start, so the request is dropped.
- done and kill in the same cycle: done is still observed in that cycle; the consumer must gate it with its own flush.
- Back-to-back operation: a new start is accepted in the IDLE cycle immediately after done.
- rs1, rs2 and sel may change freely after acceptance; the latched copies are used.

Test Plan:
- DIV 100/7 (sel=00), one start pulse -> busy during CALC; done in cycle 33 after acceptance; rd=14. REM (sel=10) on the same operands -> rd=2.
- DIV -7/2 -> rd=0xFFFFFFFD (-3). REM -7/2 -> rd=0xFFFFFFFF (-1). REM 7/-2 -> rd=1. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF/2 -> 1.
- Divide by zero, rs1=0x12345678, rs2=0 -> DIV/DIVU rd=0xFFFFFFFF; REM/REMU rd=0x12345678; done one cycle after acceptance.
- Overflow, rs1=0x80000000, rs2=0xFFFFFFFF -> DIV rd=0x80000000; REM rd=0; done one cycle after acceptance. Same operands with DIVU -> normal path, rd=0 after 33 cycles.
- Assert kill at iteration 10 -> next cycle busy=0, no done pulse, rd keeps its previous value. A start the following cycle completes correctly.
- Pulse start again at iteration 5 with different operands -> ignored; the result is for the first operands. Assert rst mid-CALC -> outputs zero immediately, without waiting for a clock edge.
